// File: rtl/seq_pkg.sv
// Shared types and helpers for the program sequencer: FSM state encoding,
// the default start-address table and target sign extension.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  // Program 0 sits in the low 16 bits.
  localparam logic [47:0] START_ADDRS_DEF = {16'd256, 16'd128, 16'd0};

  // Sign-extend the low tw bits of tgt to 32 bits; callers truncate to their PC width.
  function automatic logic [31:0] sext_tgt(input logic [31:0] tgt, input int tw);
    return 32'($signed(tgt << (32 - tw)) >>> (32 - tw));
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for an unstalled, non-terminating RUN cycle:
// absolute jump, taken relative branch, or sequential increment.
module pc_next_calc
  import seq_pkg::*;
#(
  parameter int A  = 16,
  parameter int TW = 8
) (
  input  logic [A-1:0]  i_pc,
  input  logic [TW-1:0] i_target,
  input  logic          i_branch_abs,
  input  logic          i_branch_rel,
  input  logic          i_alu_zero,
  output logic [A-1:0]  o_pc_next
);

  logic [A-1:0] w_rel_off;

  assign w_rel_off = A'(sext_tgt(32'(i_target), TW));

  // Additions wrap modulo 2^A by construction of the A-bit result.
  always_comb begin
    o_pc_next = i_pc + A'(1);
    if (i_branch_abs) begin
      o_pc_next = A'(i_target);
    end else if (i_branch_rel && i_alu_zero) begin
      o_pc_next = i_pc + w_rel_off;
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: PC, multi-program start table, run-cycle counter with
// optional timeout, and a four-phase req/ack handshake towards the bench.
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int                 A           = 16,
  parameter int                 TW          = 8,
  parameter int                 NPROG       = 3,
  parameter logic [NPROG*A-1:0] START_ADDRS = START_ADDRS_DEF,
  parameter logic [A-1:0]       HALT_ADDR   = 16'hFFFF,
  parameter int                 CW          = 16,
  parameter int unsigned        TIMEOUT     = 0,
  localparam int                PW          = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  output logic          ack,
  input  logic          branch_rel,
  input  logic          alu_zero,
  input  logic          branch_abs,
  input  logic [TW-1:0] target,
  input  logic          halt_insn,
  input  logic          stall,
  output logic [A-1:0]  pc,
  output logic          running,
  output logic [PW-1:0] prog_idx,
  output logic [CW-1:0] cycle_ct,
  output logic          timed_out,
  output logic [1:0]    dbg_state
);

  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(NPROG - 1);

  seq_state_t    r_state, w_state_nxt;
  logic [A-1:0]  r_pc, w_pc_nxt, w_pc_calc, w_start_pc;
  logic          r_ack, r_running, r_timed_out, w_to_nxt;
  logic [PW-1:0] r_prog_idx, w_idx_nxt;
  logic [CW-1:0] r_cycle_ct, w_ct_nxt;
  logic          w_halt_hit, w_to_hit;

  pc_next_calc #(.A(A), .TW(TW)) u_pc_next (
    .i_pc         (r_pc),
    .i_target     (target),
    .i_branch_abs (branch_abs),
    .i_branch_rel (branch_rel),
    .i_alu_zero   (alu_zero),
    .o_pc_next    (w_pc_calc)
  );

  always_comb begin
    w_start_pc = '0;
    for (int p = 0; p < NPROG; p++) begin
      if (r_prog_idx == PW'(p)) w_start_pc = START_ADDRS[p*A +: A];
    end
  end

  assign w_halt_hit = halt_insn || (r_pc == HALT_ADDR);
  assign w_to_hit   = (TIMEOUT != 0) && (r_cycle_ct == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_idx_nxt   = r_prog_idx;
    w_ct_nxt    = r_cycle_ct;
    w_to_nxt    = r_timed_out;
    case (r_state)
      IDLE: begin
        if (req) begin
          w_state_nxt = RUN;
          w_pc_nxt    = w_start_pc;
          w_ct_nxt    = '0;
          w_to_nxt    = 1'b0;
        end
      end
      RUN: begin
        w_ct_nxt = (&r_cycle_ct) ? r_cycle_ct : r_cycle_ct + CW'(1);
        // A stalled cycle carries no valid instruction, so it cannot terminate or branch.
        if (!stall) begin
          if (w_halt_hit || w_to_hit) begin
            w_state_nxt = DONE;
            w_to_nxt    = w_to_hit && !w_halt_hit;
          end else begin
            w_pc_nxt = w_pc_calc;
          end
        end
      end
      DONE: begin
        if (!req) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = (r_prog_idx == LAST_IDX) ? '0 : r_prog_idx + PW'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_pc        <= '0;
      r_ack       <= 1'b0;
      r_running   <= 1'b0;
      r_prog_idx  <= '0;
      r_cycle_ct  <= '0;
      r_timed_out <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_ack       <= (w_state_nxt == DONE);
      r_running   <= (w_state_nxt == RUN);
      r_prog_idx  <= w_idx_nxt;
      r_cycle_ct  <= w_ct_nxt;
      r_timed_out <= w_to_nxt;
    end
  end

  assign pc        = r_pc;
  assign ack       = r_ack;
  assign running   = r_running;
  assign prog_idx  = r_prog_idx;
  assign cycle_ct  = r_cycle_ct;
  assign timed_out = r_timed_out;
  assign dbg_state = r_state;

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised program sequencer for the next-generation core: program counter, branch/next-PC logic, multi-program start table and bench req/ack handshake in one sequential block.
- Replaces the current fetch-plus-ack arrangement, in which ack is a combinational compare of PC against a fixed halt address.
- Drives the instruction ROM address, takes branch/halt/stall qualifiers from decode and ALU, and reports a run-cycle count and timeout status.

Parameters:
A, 16, PC / instruction address width
TW, 8, branch target/offset width; relative offsets are sign-extended to A
NPROG, 3, number of programs in the start table; 1 or more
START_ADDRS, {16'd256,16'd128,16'd0}, packed start addresses, A bits each; program 0 occupies bits [A-1:0]
HALT_ADDR, 16'hFFFF, PC value that terminates a run
CW, 16, cycle counter width
TIMEOUT, 0, run-cycle limit; 0 disables the limit

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
req  in  1  bench request: start the next program
ack  out  1  program done; held until req falls
branch_rel  in  1  relative branch, taken when alu_zero=1
alu_zero  in  1  ALU zero flag
branch_abs  in  1  unconditional absolute jump to zero-extended target
target  in  TW  branch offset (relative) or absolute address
halt_insn  in  1  decoded halt instruction
stall  in  1  hold PC this cycle (instruction not valid)
pc  out  A  instruction address
running  out  1  high in RUN state
prog_idx  out  max(1,$clog2(NPROG))  program to run on next req
cycle_ct  out  CW  RUN cycles of the current or last program
timed_out  out  1  last run ended by TIMEOUT

Behaviour:
- Reset is synchronous, evaluated on the clk rising edge, and takes priority over all other inputs, including mid-run.
- Reset values:
  - state=IDLE, pc=0, ack=0, running=0
  - prog_idx=0, cycle_ct=0, timed_out=0
- All outputs are registered.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - req=1 moves to RUN on the next edge.
  - That edge loads pc=START_ADDRS[prog_idx], cycle_ct=0, timed_out=0.
  - req=0 holds all state.
- RUN:
  - running=1; cycle_ct increments every RUN cycle, including stalled ones, and saturates at all-ones.
  - Priority per cycle: stall > terminate > branch_abs > branch_rel > increment.
  - stall=1: pc holds; halt_insn and both branches are ignored.
  - Terminate when halt_insn=1, or pc==HALT_ADDR, or (TIMEOUT!=0 and cycle_ct==TIMEOUT-1). On termination:
    - move to DONE with pc unchanged
    - set timed_out=1 only when the timeout was the sole cause
  - branch_abs=1: pc <= zero-extended target.
  - branch_rel=1 and alu_zero=1: pc <= pc + sign-extended target, modulo 2^A.
  - branch_rel=1 and alu_zero=0: pc <= pc+1.
  - Otherwise pc <= pc+1, wrapping from 2^A-1 to 0.
  - req is ignored in RUN.
- DONE:
  - ack=1 and running=0; pc and cycle_ct hold.
  - When req=0: next edge sets ack=0, state=IDLE, prog_idx=(prog_idx+1) mod NPROG.
  - While req stays 1, remain in DONE. This is a four-phase handshake: no new run starts until req has dropped and risen again.
- ack rises exactly one cycle after the terminating cycle; pc is never HALT_ADDR+1 afterwards.
- prog_idx wraps from NPROG-1 to 0. With NPROG=1 it stays 0.

Decomposition:
- Shared package seq_pkg holds:
  - state enum seq_state_t {IDLE, RUN, DONE}
  - function sext_tgt (TW to A sign extension)
  - START_ADDRS default constant for the core
- One natural sub-module: pc_next_calc, purely combinational.
  - Inputs: pc, target, branch_abs, branch_rel, alu_zero.
  - Output: next PC.
- The FSM, counters and handshake stay in prog_sequencer.

Test Plan:
- Reset, then req=1 → pc=0x0000 one cycle later, running=1. With no branches, pc counts 0,1,2. Halt_insn at pc=5 → next cycle ack=1, pc=5, cycle_ct=6. Drop req → ack=0, prog_idx=1.
- Second req → pc=0x0080. target=8'hFE with branch_rel=1, alu_zero=1 at pc=0x0085 → pc=0x0083. Same with alu_zero=0 → pc=0x0086.
- branch_abs with target=8'h40 and simultaneous halt_insn → halt wins: DONE, pc unchanged. stall=1 with halt_insn=1 → no halt, pc held, cycle_ct increments.
- TIMEOUT=10, endless loop (branch_abs to self) → ack after exactly 10 RUN cycles, timed_out=1, cycle_ct=10. Next run clears timed_out.
- Run three programs back-to-back → prog_idx 0→1→2→0, start PCs 0, 0x80, 0x100, 0. Holding req high in DONE keeps ack=1 and starts no new run.
- Assert reset mid-RUN at pc=0x0103 → next cycle: IDLE, pc=0, ack=0, prog_idx=0, cycle_ct=0. pc stepping from 0xFFFF is not possible since HALT_ADDR terminates; separately, with HALT_ADDR=0x0010 and target wrap: pc=0x0002 with offset 0x80 → pc=0xFF82.
